// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and helpers for the SCAN elevator controller
// Purpose: controller state encoding, travel-direction constants and the
//          sizing function for the tick counters.
// Ports:   none (package)
package elevator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MOVE = 3'd1,
      ST_DOOR = 3'd2,
      ST_HOLD = 3'd3,
      ST_SOS  = 3'd4
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // A tick counter runs 0..ticks-1 and fires on the last value, so it
   // only needs to hold ticks-1; keep at least one bit for ticks==1.
   function automatic int tick_cnt_w(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// rtl/elevator_req_scan.sv - pending-call register with ahead-above/ahead-below detect
// Purpose: latches call pulses into the pending set and reports whether any
//          call (latched or arriving this cycle) lies above or below a floor.
// Ports:
//   clk, button_reset_n  clock, synchronous active-low reset
//   call_req             incoming call pulses, one bit per floor
//   latch_en             0 drops incoming calls (emergency lockout)
//   flush                clears every pending call
//   drop_mask            bits removed from the pending set this cycle
//   eval_floor           floor the above/below detect is measured from
//   pending              latched, not-yet-served calls
//   req_all              pending plus accepted calls of this cycle
//   ahead_up, ahead_dn   some request strictly above / below eval_floor
module elevator_req_scan
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  button_reset_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic                  latch_en,
   input  logic                  flush,
   input  logic [NUM_FLOORS-1:0] drop_mask,
   input  logic [FLOOR_W-1:0]    eval_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [NUM_FLOORS-1:0] req_all,
   output logic                  ahead_up,
   output logic                  ahead_dn
);

   logic [NUM_FLOORS-1:0] above_mask;
   logic [NUM_FLOORS-1:0] below_mask;

   always_comb begin
      req_all = pending | (latch_en ? call_req : '0);
   end

   always_comb begin
      above_mask = '0;
      below_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         above_mask[i] = (FLOOR_W'(i) > eval_floor);
         below_mask[i] = (FLOOR_W'(i) < eval_floor);
      end
      ahead_up = |(req_all & above_mask);
      ahead_dn = |(req_all & below_mask);
   end

   always_ff @(posedge clk) begin
      if (!button_reset_n) begin
         pending <= '0;
      end else if (flush) begin
         pending <= '0;
      end else begin
         pending <= req_all & ~drop_mask;
      end
   end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - single-car SCAN elevator controller
// Purpose: serves latched calls in SCAN order with timed floor-to-floor
//          travel, door dwell, overweight hold and emergency lockout, all on
//          one clock qualified by a shared tick enable.
// Ports:
//   clk, button_reset_n    clock, synchronous active-low reset
//   tick                   one-cycle timing enable
//   call_req               call pulses, bit i = floor i
//   weight_limit_exceeded  car overloaded (level)
//   sos_mode               emergency lockout (level)
//   floor                  current floor
//   moving                 travelling between floors
//   dir_up                 current/last travel direction
//   door_open              door open
//   pending                latched, unserved calls
//   alarm                  emergency lockout active
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS),
   parameter int MOVE_TICKS = 4,
   parameter int DOOR_TICKS = 6
) (
   input  logic                  clk,
   input  logic                  button_reset_n,
   input  logic                  tick,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic                  weight_limit_exceeded,
   input  logic                  sos_mode,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  alarm
);

   localparam int MCNT_W = tick_cnt_w(MOVE_TICKS);
   localparam int DCNT_W = tick_cnt_w(DOOR_TICKS);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [MCNT_W-1:0]  MCNT_LAST = MCNT_W'(MOVE_TICKS - 1);
   localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DOOR_TICKS - 1);

   state_t                state, state_nxt;
   logic [MCNT_W-1:0]     move_cnt, move_cnt_nxt;
   logic [DCNT_W-1:0]     door_cnt, door_cnt_nxt;
   logic [FLOOR_W-1:0]    floor_nxt;
   logic [FLOOR_W-1:0]    step_floor;
   logic [FLOOR_W-1:0]    eval_floor;
   logic                  dir_nxt;
   logic                  at_edge;
   logic                  arrive;
   logic                  flush;
   logic                  latch_en;
   logic [NUM_FLOORS-1:0] drop_mask;
   logic [NUM_FLOORS-1:0] cur_mask;
   logic [NUM_FLOORS-1:0] step_mask;
   logic [NUM_FLOORS-1:0] req_all;
   logic                  ahead_up;
   logic                  ahead_dn;
   logic                  ahead;

   // Travel geometry: the floor the car would reach next, and whether it is
   // already at the end of the shaft in its current direction.
   always_comb begin
      at_edge    = dir_up ? (floor == TOP_FLOOR) : (floor == '0);
      step_floor = dir_up ? floor + 1'b1 : floor - 1'b1;
      cur_mask   = NUM_FLOORS'(1) << floor;
      step_mask  = NUM_FLOORS'(1) << step_floor;
      arrive     = (state == ST_MOVE) && tick && (move_cnt == MCNT_LAST)
                   && !sos_mode && !at_edge;
      // On arrival the "anything ahead" question is asked of the new floor.
      eval_floor = arrive ? step_floor : floor;
      ahead      = dir_up ? ahead_up : ahead_dn;
   end

   elevator_req_scan #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_req_scan (
      .clk            (clk),
      .button_reset_n (button_reset_n),
      .call_req       (call_req),
      .latch_en       (latch_en),
      .flush          (flush),
      .drop_mask      (drop_mask),
      .eval_floor     (eval_floor),
      .pending        (pending),
      .req_all        (req_all),
      .ahead_up       (ahead_up),
      .ahead_dn       (ahead_dn)
   );

   always_comb begin
      state_nxt    = state;
      floor_nxt    = floor;
      dir_nxt      = dir_up;
      move_cnt_nxt = move_cnt;
      door_cnt_nxt = door_cnt;
      flush        = 1'b0;
      latch_en     = 1'b1;
      drop_mask    = '0;

      if (sos_mode) begin
         state_nxt    = ST_SOS;
         flush        = 1'b1;
         latch_en     = 1'b0;
         move_cnt_nxt = '0;
         door_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A call for this floor opens the door instead of being latched.
               drop_mask = cur_mask;
               if (req_all[floor]) begin
                  state_nxt    = ST_DOOR;
                  door_cnt_nxt = '0;
               end else if (|req_all) begin
                  state_nxt    = ST_MOVE;
                  move_cnt_nxt = '0;
                  if (!ahead) begin
                     dir_nxt = ~dir_up;
                  end
               end
            end

            ST_MOVE: begin
               if (tick) begin
                  if (move_cnt == MCNT_LAST) begin
                     move_cnt_nxt = '0;
                     if (at_edge) begin
                        // Cannot go further this way; let IDLE pick again.
                        state_nxt = ST_IDLE;
                     end else begin
                        floor_nxt = step_floor;
                        drop_mask = step_mask;
                        if (req_all[step_floor]) begin
                           state_nxt    = ST_DOOR;
                           door_cnt_nxt = '0;
                        end else if (!ahead) begin
                           if (|(req_all & ~step_mask)) begin
                              dir_nxt = ~dir_up;
                           end else begin
                              state_nxt = ST_IDLE;
                           end
                        end
                     end
                  end else begin
                     move_cnt_nxt = move_cnt + 1'b1;
                  end
               end
            end

            ST_DOOR: begin
               drop_mask = cur_mask;
               if (call_req[floor]) begin
                  door_cnt_nxt = '0;
               end else if (tick) begin
                  if (door_cnt == DCNT_LAST) begin
                     door_cnt_nxt = '0;
                     state_nxt    = weight_limit_exceeded ? ST_HOLD : ST_IDLE;
                  end else begin
                     door_cnt_nxt = door_cnt + 1'b1;
                  end
               end
            end

            ST_HOLD: begin
               if (!weight_limit_exceeded) begin
                  state_nxt    = ST_DOOR;
                  door_cnt_nxt = '0;
               end
            end

            ST_SOS: begin
               latch_en  = 1'b0;
               state_nxt = ST_IDLE;
            end

            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!button_reset_n) begin
         state     <= ST_IDLE;
         floor     <= '0;
         dir_up    <= DIR_UP;
         move_cnt  <= '0;
         door_cnt  <= '0;
         moving    <= 1'b0;
         door_open <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         state     <= state_nxt;
         floor     <= floor_nxt;
         dir_up    <= dir_nxt;
         move_cnt  <= move_cnt_nxt;
         door_cnt  <= door_cnt_nxt;
         moving    <= (state_nxt == ST_MOVE);
         door_open <= (state_nxt == ST_DOOR) || (state_nxt == ST_HOLD);
         alarm     <= (state_nxt == ST_SOS);
      end
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - directed self-checking bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;

   logic [7:0] call_a;
   logic       wt_a, sos_a;
   logic [2:0] floor_a;
   logic       moving_a, dir_a, door_a, alarm_a;
   logic [7:0] pend_a;

   logic [2:0] call_b;
   logic       wt_b, sos_b;
   logic [1:0] floor_b;
   logic       moving_b, dir_b, door_b, alarm_b;
   logic [2:0] pend_b;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   elevator_scan_ctrl dut_a (
      .clk                   (clk),
      .button_reset_n        (rst_n),
      .tick                  (tick),
      .call_req              (call_a),
      .weight_limit_exceeded (wt_a),
      .sos_mode              (sos_a),
      .floor                 (floor_a),
      .moving                (moving_a),
      .dir_up                (dir_a),
      .door_open             (door_a),
      .pending               (pend_a),
      .alarm                 (alarm_a)
   );

   elevator_scan_ctrl #(.NUM_FLOORS(3)) dut_b (
      .clk                   (clk),
      .button_reset_n        (rst_n),
      .tick                  (tick),
      .call_req              (call_b),
      .weight_limit_exceeded (wt_b),
      .sos_mode              (sos_b),
      .floor                 (floor_b),
      .moving                (moving_b),
      .dir_up                (dir_b),
      .door_open             (door_b),
      .pending               (pend_b),
      .alarm                 (alarm_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      rst_n  = 1'b0;
      tick   = 1'b1;
      call_a = '0; wt_a = 1'b0; sos_a = 1'b0;
      call_b = '0; wt_b = 1'b0; sos_b = 1'b0;
      step(2);

      // Reset state
      check("rst_floor",  32'(floor_a),  0);
      check("rst_moving", 32'(moving_a), 0);
      check("rst_dir",    32'(dir_a),    1);
      check("rst_door",   32'(door_a),   0);
      check("rst_pend",   32'(pend_a),   0);
      check("rst_alarm",  32'(alarm_a),  0);
      rst_n = 1'b1;
      step(1);
      check("idle_nocall", 32'(moving_a), 0);

      // 1: call floor 5 from 0, 4 ticks per floor, door dwell with restart
      call_a = 8'h20; step(1); call_a = '0;
      check("t1_moving", 32'(moving_a), 1);
      check("t1_pend",   32'(pend_a),   32'h20);
      check("t1_floor0", 32'(floor_a),  0);
      step(3);
      check("t1_floor0_late", 32'(floor_a), 0);
      step(1);
      check("t1_floor1", 32'(floor_a), 1);
      for (int f = 2; f <= 5; f++) begin
         step(4);
         check("t1_floor_n", 32'(floor_a), 32'(f));
      end
      check("t1_arr_door",   32'(door_a),   1);
      check("t1_arr_moving", 32'(moving_a), 0);
      check("t1_arr_pend",   32'(pend_a),   0);
      step(3);
      call_a = 8'h20; step(1); call_a = '0;
      check("t1_restart_door", 32'(door_a), 1);
      check("t1_restart_pend", 32'(pend_a), 0);
      step(5);
      check("t1_dwell_open",   32'(door_a), 1);
      step(1);
      check("t1_dwell_closed", 32'(door_a), 0);

      // 2: at 4 going up with {2,6}: serve 6, reverse, stop at 2
      do_reset();
      call_a = 8'h40; step(1); call_a = '0;
      step(16);
      check("t2_floor4", 32'(floor_a), 4);
      call_a = 8'h04; step(1); call_a = '0;
      check("t2_pend",  32'(pend_a), 32'h44);
      check("t2_dirup", 32'(dir_a),  1);
      step(3);
      check("t2_floor5", 32'(floor_a), 5);
      step(4);
      check("t2_floor6", 32'(floor_a), 6);
      check("t2_door6",  32'(door_a),  1);
      check("t2_pend6",  32'(pend_a),  32'h04);
      step(6);
      check("t2_closed6", 32'(door_a), 0);
      step(1);
      check("t2_rev_moving", 32'(moving_a), 1);
      check("t2_rev_dir",    32'(dir_a),    0);
      step(16);
      check("t2_floor2", 32'(floor_a), 2);
      check("t2_door2",  32'(door_a),  1);
      check("t2_pend2",  32'(pend_a),  0);

      // 3: overweight hold at floor 3, then depart to pending 6
      do_reset();
      call_a = 8'h08; step(1); call_a = '0;
      step(12);
      check("t3_floor3", 32'(floor_a), 3);
      check("t3_door",   32'(door_a),  1);
      call_a = 8'h40; wt_a = 1'b1; step(1); call_a = '0;
      check("t3_pend", 32'(pend_a), 32'h40);
      step(5);
      check("t3_hold_door", 32'(door_a), 1);
      step(5);
      check("t3_hold_door2",   32'(door_a),   1);
      check("t3_hold_moving",  32'(moving_a), 0);
      check("t3_hold_floor",   32'(floor_a),  3);
      wt_a = 1'b0; step(1);
      check("t3_redoor", 32'(door_a), 1);
      step(5);
      check("t3_dwell_open", 32'(door_a), 1);
      step(1);
      check("t3_dwell_closed", 32'(door_a),   0);
      check("t3_not_moving",   32'(moving_a), 0);
      step(1);
      check("t3_depart", 32'(moving_a), 1);
      check("t3_dir",    32'(dir_a),    1);

      // 4: SOS mid-transit 2->3
      do_reset();
      call_a = 8'h20; step(1); call_a = '0;
      step(8);
      check("t4_floor2", 32'(floor_a), 2);
      step(2);
      sos_a = 1'b1; call_a = 8'h80; step(1); call_a = '0;
      check("t4_moving", 32'(moving_a), 0);
      check("t4_alarm",  32'(alarm_a),  1);
      check("t4_floor",  32'(floor_a),  2);
      check("t4_pend",   32'(pend_a),   0);
      check("t4_door",   32'(door_a),   0);
      call_a = 8'hff; step(3); call_a = '0;
      check("t4_ignored", 32'(pend_a),  0);
      check("t4_alarm2",  32'(alarm_a), 1);
      check("t4_floor2b", 32'(floor_a), 2);
      sos_a = 1'b0; step(1);
      check("t4_rel_alarm",  32'(alarm_a),  0);
      check("t4_rel_moving", 32'(moving_a), 0);
      step(2);
      check("t4_idle_stay", 32'(moving_a), 0);
      check("t4_idle_floor", 32'(floor_a), 2);

      // 5: reset during MOVE at floor 6, then tick gating from a clean counter
      do_reset();
      call_a = 8'h80; step(1); call_a = '0;
      step(24);
      check("t5_floor6", 32'(floor_a), 6);
      step(1);
      rst_n = 1'b0; call_a = 8'h08; step(1); call_a = '0; rst_n = 1'b1;
      check("t5_floor",  32'(floor_a),  0);
      check("t5_moving", 32'(moving_a), 0);
      check("t5_dir",    32'(dir_a),    1);
      check("t5_door",   32'(door_a),   0);
      check("t5_pend",   32'(pend_a),   0);
      check("t5_alarm",  32'(alarm_a),  0);
      step(1);
      check("t5_idle", 32'(moving_a), 0);
      tick = 1'b0;
      call_a = 8'h02; step(1); call_a = '0;
      check("t5_go", 32'(moving_a), 1);
      step(6);
      check("t5_notick_floor", 32'(floor_a), 0);
      tick = 1'b1;
      step(3);
      check("t5_floor0", 32'(floor_a), 0);
      step(1);
      check("t5_floor1", 32'(floor_a), 1);
      check("t5_door1",  32'(door_a),  1);

      // 6: three-floor car
      do_reset();
      call_b = 3'b001; step(1); call_b = '0;
      check("t6_door0",   32'(door_b),   1);
      check("t6_moving0", 32'(moving_b), 0);
      check("t6_pend0",   32'(pend_b),   0);
      check("t6_floor0",  32'(floor_b),  0);
      step(6);
      check("t6_closed0", 32'(door_b), 0);
      call_b = 3'b100; step(1); call_b = '0;
      check("t6_moving", 32'(moving_b), 1);
      step(4);
      check("t6_floor1", 32'(floor_b), 1);
      step(4);
      check("t6_floor2",  32'(floor_b),  2);
      check("t6_door2",   32'(door_b),   1);
      check("t6_pend2",   32'(pend_b),   0);
      step(20);
      check("t6_stay_floor",  32'(floor_b),  2);
      check("t6_stay_moving", 32'(moving_b), 0);
      check("t6_stay_door",   32'(door_b),   0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
